// File: rtl/mips_perf_pkg.sv
// Shared types and counter index map for the MIPS-Lite performance monitor.
package mips_perf_pkg;

    typedef enum logic [2:0] {
        ARITH  = 3'd0,
        LOGIC  = 3'd1,
        MEM    = 3'd2,
        BRANCH = 3'd3,
        HALT   = 3'd4
    } instr_class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_e;

    localparam int IDX_TOTAL   = 0;
    localparam int IDX_ARITH   = 1;
    localparam int IDX_LOGIC   = 2;
    localparam int IDX_MEM     = 3;
    localparam int IDX_CTRL    = 4;
    localparam int IDX_TAKEN   = 5;
    localparam int IDX_CYCLES  = 6;
    localparam int IDX_STALL   = 7;
    localparam int IDX_HAZARDS = 8;
    localparam int NUM_CNT     = 9;

endpackage

// File: rtl/mips_perf_monitor_if.sv
// Event/read bus between the pipeline core (master) and the perf monitor (slave).
interface mips_perf_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             clear;
    logic             retire_valid;
    logic [2:0]       retire_class;
    logic             branch_taken;
    logic             stall;
    logic             hazard_start;
    logic [3:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             done;

    modport master (
        output start, clear, retire_valid, retire_class, branch_taken,
               stall, hazard_start, rd_addr,
        input  rd_data, done
    );

    modport slave (
        input  start, clear, retire_valid, retire_class, branch_taken,
               stall, hazard_start, rd_addr,
        output rd_data, done
    );
endinterface

// File: rtl/perf_counter.sv
// One event counter; wraps by default, saturates when MIPS_PERF_SATURATE_EN is defined.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_max;

`ifdef MIPS_PERF_SATURATE_EN
    assign at_max = &cnt_q;
`else
    assign at_max = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && inc_i && !at_max)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/mips_perf_monitor.sv
// Perf monitor top: IDLE/RUN/DONE FSM, event decode, counter array and registered read port.
// Overflow mode selected by MIPS_PERF_SATURATE_EN (see perf_counter).
module mips_perf_monitor
    import mips_perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic        clock,
    input logic        reset_n,
    mips_perf_if.slave bus
);
    perf_state_e state_q, state_d;
    logic        cnt_en, done;
    logic [NUM_CNT-1:0]            inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]              rd_data_q, rd_data_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // clear dominates every transition, including a same-cycle start
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = RUN;
                RUN:     if (bus.retire_valid && bus.retire_class == HALT) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_en = (state_q == RUN);
        done   = (state_q == DONE);
    end

    always_comb begin
        inc             = '0;
        inc[IDX_CYCLES] = 1'b1;
        inc[IDX_STALL]  = bus.stall;
        inc[IDX_HAZARDS] = bus.hazard_start;
        if (bus.retire_valid) begin
            inc[IDX_TOTAL] = 1'b1;
            case (bus.retire_class)
                ARITH:  inc[IDX_ARITH] = 1'b1;
                LOGIC:  inc[IDX_LOGIC] = 1'b1;
                MEM:    inc[IDX_MEM]   = 1'b1;
                BRANCH: begin
                    inc[IDX_CTRL]  = 1'b1;
                    inc[IDX_TAKEN] = bus.branch_taken;
                end
                HALT:   inc[IDX_CTRL] = 1'b1;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .clr_i   (bus.clear),
            .en_i    (cnt_en),
            .inc_i   (inc[g]),
            .cnt_o   (cnt[g])
        );
    end

    always_comb begin
        rd_data_d = '0;
        if (int'(bus.rd_addr) < NUM_CNT)
            rd_data_d = cnt[bus.rd_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_data_q <= '0;
        else          rd_data_q <= rd_data_d;
    end

    assign bus.rd_data = rd_data_q;
    assign bus.done    = done;
endmodule

// File: tb/tb_mips_perf_monitor.sv
// Randomized + directed bench; a 32-bit and a 4-bit monitor share stimulus against an unbounded-count model.
module tb_mips_perf_monitor;

    logic clock, reset_n;
    int   n_chk, n_err;

    mips_perf_if #(.CNT_W(32)) bus32 ();
    mips_perf_if #(.CNT_W(4))  bus4 ();

    mips_perf_monitor #(.CNT_W(32)) dut32 (.clock(clock), .reset_n(reset_n), .bus(bus32));
    mips_perf_monitor #(.CNT_W(4))  dut4  (.clock(clock), .reset_n(reset_n), .bus(bus4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // model: true event counts, clipped to the counter width only when read
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    longint m_cnt[9];
    int     m_st;
    longint exp32, exp4;

    function automatic longint clipv(longint c, int w);
        longint mx = (longint'(1) << w) - 1;
`ifdef MIPS_PERF_SATURATE_EN
        return (c > mx) ? mx : c;
`else
        return c & mx;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_st = M_IDLE;
    endtask

    task automatic cycle(input bit st, input bit cl, input bit rv, input int cls,
                         input bit tk, input bit sl, input bit hz, input int addr);
        bus32.start = st; bus32.clear = cl; bus32.retire_valid = rv;
        bus32.retire_class = 3'(cls); bus32.branch_taken = tk; bus32.stall = sl;
        bus32.hazard_start = hz; bus32.rd_addr = 4'(addr);
        bus4.start = st; bus4.clear = cl; bus4.retire_valid = rv;
        bus4.retire_class = 3'(cls); bus4.branch_taken = tk; bus4.stall = sl;
        bus4.hazard_start = hz; bus4.rd_addr = 4'(addr);
        // read port samples counter contents before this edge's updates
        exp32 = (addr < 9) ? clipv(m_cnt[addr], 32) : 0;
        exp4  = (addr < 9) ? clipv(m_cnt[addr], 4)  : 0;
        if (cl) begin
            model_reset();
        end else if (m_st == M_IDLE) begin
            if (st) m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            m_cnt[6]++;
            if (sl) m_cnt[7]++;
            if (hz) m_cnt[8]++;
            if (rv) begin
                m_cnt[0]++;
                if (cls <= 2) m_cnt[cls + 1]++;
                if (cls == 3 || cls == 4) m_cnt[4]++;
                if (cls == 3 && tk) m_cnt[5]++;
                if (cls == 4) m_st = M_DONE;
            end
        end
        @(posedge clock);
        @(negedge clock);
        chk("rd32", 64'(bus32.rd_data), 64'(exp32));
        chk("rd4", 64'(bus4.rd_data), 64'(exp4));
        chk("done32", 64'(bus32.done), 64'(m_st == M_DONE));
        chk("done4", 64'(bus4.done), 64'(m_st == M_DONE));
    endtask

    task automatic idle(input int addr);
        cycle(0, 0, 0, 0, 0, 0, 0, addr);
    endtask

    task automatic rd(input string tag, input int addr, input longint exp);
        idle(addr);
        chk(tag, 64'(bus32.rd_data), 64'(exp));
    endtask

    task automatic ret(input int cls, input bit tk);
        cycle(0, 0, 1, cls, tk, 0, 0, 0);
    endtask

    int cls_tab[7] = '{0, 1, 2, 3, 5, 6, 7};

    initial begin
        n_chk = 0; n_err = 0;
        model_reset();
        reset_n = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_rd", 64'(bus32.rd_data), 64'd0);
        chk("rst_done", 64'(bus32.done), 64'd0);
        reset_n = 1'b1;

        // instruction mix
        idle(0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) ret(0, 0);
        repeat (2) ret(1, 0);
        repeat (2) ret(2, 0);
        ret(3, 1);
        ret(3, 0);
        ret(4, 0);
        chk("mix_done", 64'(bus32.done), 64'd1);
        rd("mix_total", 0, 10); rd("mix_arith", 1, 3); rd("mix_logic", 2, 2);
        rd("mix_mem", 3, 2);    rd("mix_ctrl", 4, 3);  rd("mix_taken", 5, 1);
        rd("mix_cycles", 6, 10);

        // frozen in DONE
        repeat (5) ret(0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        rd("frz_total", 0, 10);
        rd("frz_cycles", 6, 10);
        chk("frz_done", 64'(bus32.done), 64'd1);

        // clear wins over start
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) rd("clr_rd", k, 0);
        chk("clr_done", 64'(bus32.done), 64'd0);
        ret(0, 0);
        rd("clr_idle", 0, 0);

        // stalls and hazards
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        ret(4, 0);
        rd("sh_stall", 7, 4); rd("sh_haz", 8, 2);
        chk("sh_done", 64'(bus32.done), 64'd1);

        // overflow on the 4-bit instance
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (20) idle(6);
        idle(6);
`ifdef MIPS_PERF_SATURATE_EN
        chk("ovf_cyc4", 64'(bus4.rd_data), 64'd15);
`else
        chk("ovf_cyc4", 64'(bus4.rd_data), 64'd4);
`endif

        // reserved class and out-of-range read
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        ret(6, 1);
        rd("rsv_total", 0, 1); rd("rsv_arith", 1, 0); rd("rsv_ctrl", 4, 0);
        rd("rsv_taken", 5, 0); rd("rd_addr12", 12, 0);

        // async reset mid-RUN
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) ret(0, 0);
        rd("pre_rst_total", 0, 7);
        idle(0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_rd", 64'(bus32.rd_data), 64'd0);
        chk("arst_done", 64'(bus32.done), 64'd0);
        model_reset();
        #1 reset_n = 1'b1;
        repeat (3) ret(1, 0);
        rd("arst_idle_total", 0, 0);
        rd("arst_idle_cyc", 6, 0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int r, c;
            r = $urandom_range(0, 99);
            c = (r < 4) ? 4 : cls_tab[$urandom_range(0, 6)];
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 79) == 0),
                  $urandom_range(0, 1), c, $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 15));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
